// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the writeback arbiter.
package wb_arb_pkg;

    localparam int WB_NUM_PORTS = 2;
    localparam int WB_NUM_PR    = 64;

    localparam int WB_NUM_REQ = 4;
    localparam int WB_PR_W    = $clog2(WB_NUM_PR);
    localparam int WB_DATA_W  = 32;
    localparam int WB_BR_W    = 4;
    localparam int WB_IDX_W   = (WB_NUM_REQ > 1) ? $clog2(WB_NUM_REQ) : 1;

    typedef struct packed {
        logic                 valid;
        logic [WB_PR_W-1:0]   pr;
        logic [WB_DATA_W-1:0] data;
        logic [WB_BR_W-1:0]   br_mask;
    } wb_entry_t;

    // Pointer moves one past the last winner only when something was granted.
    function automatic logic [WB_IDX_W-1:0] rr_next(input logic [WB_IDX_W-1:0] ptr,
                                                    input logic [WB_IDX_W-1:0] last,
                                                    input logic                any);
        if (!any)
            return ptr;
        if (int'(last) == WB_NUM_REQ - 1)
            return '0;
        return last + 1'b1;
    endfunction

endpackage

// File: rtl/rr_multi_select.sv
// Round-robin pick of up to P requesters starting at 'start'; winner k lands in grant[k].
// Shared with issue select, so it carries no arbiter-specific state.
module rr_multi_select #(
    parameter int N     = 4,
    parameter int P     = 2,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_W-1:0]    start,
    output logic [P-1:0][N-1:0] grant,
    output logic [P-1:0]        grant_valid,
    output logic [IDX_W-1:0]    last
);

    int pos;
    int cnt;

    always_comb begin
        grant       = '0;
        grant_valid = '0;
        last        = start;
        pos         = 0;
        cnt         = 0;
        for (int s = 0; s < N; s++) begin
            pos = int'(start) + s;
            if (pos >= N)
                pos = pos - N;
            for (int i = 0; i < N; i++) begin
                if (i == pos && req[i]) begin
                    for (int k = 0; k < P; k++) begin
                        if (k == cnt) begin
                            grant[k][i]    = 1'b1;
                            grant_valid[k] = 1'b1;
                        end
                    end
                    if (cnt < P)
                        last = IDX_W'(i);
                    cnt = cnt + 1;
                end
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the completion ports among functional units via 1-entry holding buffers and round-robin grant.
// Define WB_ARB_BYPASS_EN to let an incoming result take a spare port directly (1-cycle path).
module writeback_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ   = WB_NUM_REQ,
    parameter int NUM_PORTS = WB_NUM_PORTS,
    parameter int PR_W      = WB_PR_W,
    parameter int DATA_W    = WB_DATA_W,
    parameter int BR_W      = WB_BR_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][PR_W-1:0]     req_pr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0][BR_W-1:0]     req_br_mask,
    input  logic                             recall,
    input  logic [BR_W-1:0]                  recall_tag,
    input  logic                             resolve,
    input  logic [BR_W-1:0]                  resolve_tag,
    output logic [NUM_PORTS-1:0]             done,
    output logic [NUM_PORTS-1:0][PR_W-1:0]   done_addr,
    output logic [NUM_PORTS-1:0][DATA_W-1:0] done_data
);

    localparam int IDX_W = WB_IDX_W;

    wb_entry_t                          buf_q [NUM_REQ];
    logic [IDX_W-1:0]                   rr_ptr;
    logic [NUM_REQ-1:0]                 buf_valid, kill, elig, in_kill;
    logic [NUM_REQ-1:0]                 granted, byp_take;
    logic [BR_W-1:0]                    recall_m, resolve_m;
    logic [NUM_PORTS-1:0][NUM_REQ-1:0]  bgrant, port_grant;
    logic [NUM_PORTS-1:0]               bvalid, port_valid, port_byp;
    logic [IDX_W-1:0]                   blast, last_win;
    logic [NUM_PORTS-1:0][PR_W-1:0]     port_pr;
    logic [NUM_PORTS-1:0][DATA_W-1:0]   port_data;

    assign recall_m  = recall  ? recall_tag  : '0;
    assign resolve_m = resolve ? resolve_tag : '0;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            buf_valid[i] = buf_q[i].valid;
            kill[i]      = buf_q[i].valid & (|(buf_q[i].br_mask & recall_m));
            in_kill[i]   = |(req_br_mask[i] & recall_m);
        end
    end

    assign elig      = buf_valid & ~kill;
    assign req_ready = ~buf_valid;

    rr_multi_select #(.N(NUM_REQ), .P(NUM_PORTS), .IDX_W(IDX_W)) u_sel_buf (
        .req         (elig),
        .start       (rr_ptr),
        .grant       (bgrant),
        .grant_valid (bvalid),
        .last        (blast)
    );

`ifdef WB_ARB_BYPASS_EN
    logic [NUM_REQ-1:0]                byp_req;
    logic [NUM_PORTS-1:0][NUM_REQ-1:0] pgrant;
    logic [NUM_PORTS-1:0]              pvalid;
    logic [IDX_W-1:0]                  plast;
    logic                              unused_plast;
    int                                nb;

    assign byp_req      = req_valid & ~buf_valid & ~in_kill;
    assign unused_plast = ^plast;

    rr_multi_select #(.N(NUM_REQ), .P(NUM_PORTS), .IDX_W(IDX_W)) u_sel_byp (
        .req         (byp_req),
        .start       (rr_ptr),
        .grant       (pgrant),
        .grant_valid (pvalid),
        .last        (plast)
    );

    // Bypass winners fill the ports left over after the buffered winners, in rr order.
    always_comb begin
        nb         = 0;
        port_grant = bgrant;
        port_valid = bvalid;
        port_byp   = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            if (bvalid[k])
                nb = nb + 1;
        for (int k = 0; k < NUM_PORTS; k++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!bvalid[k] && j == k - nb && pvalid[j]) begin
                    port_grant[k] = pgrant[j];
                    port_valid[k] = 1'b1;
                    port_byp[k]   = 1'b1;
                end
            end
        end
    end
`else
    assign port_grant = bgrant;
    assign port_valid = bvalid;
    assign port_byp   = '0;
`endif

    always_comb begin
        port_pr   = '0;
        port_data = '0;
        granted   = '0;
        byp_take  = '0;
        last_win  = blast;
        for (int k = 0; k < NUM_PORTS; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (port_grant[k][i]) begin
                    granted[i]   = granted[i]  | ~port_byp[k];
                    byp_take[i]  = byp_take[i] |  port_byp[k];
                    port_pr[k]   = port_byp[k] ? req_pr[i]   : buf_q[i].pr;
                    port_data[k] = port_byp[k] ? req_data[i] : buf_q[i].data;
                    last_win     = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            done      <= '0;
            done_addr <= '0;
            done_data <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                buf_q[i] <= '0;
        end else begin
            rr_ptr <= rr_next(rr_ptr, last_win, |port_valid);
            done   <= port_valid;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (port_valid[k]) begin
                    done_addr[k] <= port_pr[k];
                    done_data[k] <= port_data[k];
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (buf_q[i].valid) begin
                    if (granted[i] || kill[i])
                        buf_q[i].valid <= 1'b0;
                    else
                        buf_q[i].br_mask <= buf_q[i].br_mask & ~resolve_m;
                end else if (req_valid[i] && !in_kill[i] && !byp_take[i]) begin
                    buf_q[i] <= '{valid: 1'b1, pr: req_pr[i], data: req_data[i],
                                  br_mask: req_br_mask[i] & ~resolve_m};
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: cycle model of buffers/rr pointer plus directed literal checks.
module tb_writeback_arbiter;
    import wb_arb_pkg::*;

    localparam int NR = WB_NUM_REQ;
    localparam int NP = WB_NUM_PORTS;
    localparam int PW = WB_PR_W;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NR-1:0]           req_valid;
    logic [NR-1:0]           req_ready;
    logic [NR-1:0][PW-1:0]   req_pr;
    logic [NR-1:0][31:0]     req_data;
    logic [NR-1:0][3:0]      req_br_mask;
    logic                    recall, resolve;
    logic [3:0]              recall_tag, resolve_tag;
    logic [NP-1:0]           done;
    logic [NP-1:0][PW-1:0]   done_addr;
    logic [NP-1:0][31:0]     done_data;

    writeback_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pr      (req_pr),
        .req_data    (req_data),
        .req_br_mask (req_br_mask),
        .recall      (recall),
        .recall_tag  (recall_tag),
        .resolve     (resolve),
        .resolve_tag (resolve_tag),
        .done        (done),
        .done_addr   (done_addr),
        .done_data   (done_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model state: what each FU's holding slot contains, and where the scan starts.
    bit              m_valid [NR];
    logic [PW-1:0]   m_pr    [NR];
    logic [31:0]     m_data  [NR];
    logic [3:0]      m_mask  [NR];
    int              m_rr;
    logic [NP-1:0]   e_done;
    logic [PW-1:0]   e_addr  [NP];
    logic [31:0]     e_data  [NP];
    logic [NR-1:0]   e_ready;
    int              low_cnt [NR];
    bit              model_on = 0;

    always @(posedge clk) begin : model
        bit         killed [NR];
        bit         taken  [NR];
        bit         byp    [NR];
        int         nwin, last, idx;
        logic [3:0] rm, sm;
        rm = recall  ? recall_tag  : 4'h0;
        sm = resolve ? resolve_tag : 4'h0;
        if (reset) begin
            model_on = 1;
            m_rr     = 0;
            e_done   = '0;
            for (int n = 0; n < NR; n++) m_valid[n] = 0;
            for (int k = 0; k < NP; k++) begin e_addr[k] = '0; e_data[k] = '0; end
        end else begin
            nwin   = 0;
            last   = -1;
            e_done = '0;
            for (int n = 0; n < NR; n++) begin
                killed[n] = m_valid[n] && ((m_mask[n] & rm) != 0);
                taken[n]  = 0;
                byp[n]    = 0;
            end
            for (int s = 0; s < NR; s++) begin
                idx = (m_rr + s) % NR;
                if (m_valid[idx] && !killed[idx] && nwin < NP) begin
                    e_done[nwin] = 1'b1;
                    e_addr[nwin] = m_pr[idx];
                    e_data[nwin] = m_data[idx];
                    taken[idx]   = 1;
                    last         = idx;
                    nwin++;
                end
            end
`ifdef WB_ARB_BYPASS_EN
            for (int s = 0; s < NR; s++) begin
                idx = (m_rr + s) % NR;
                if (nwin < NP && req_valid[idx] && !m_valid[idx] && ((req_br_mask[idx] & rm) == 0)) begin
                    e_done[nwin] = 1'b1;
                    e_addr[nwin] = req_pr[idx];
                    e_data[nwin] = req_data[idx];
                    byp[idx]     = 1;
                    last         = idx;
                    nwin++;
                end
            end
`endif
            if (last >= 0) m_rr = (last + 1) % NR;
            for (int n = 0; n < NR; n++) begin
                if (m_valid[n]) begin
                    if (taken[n] || killed[n]) m_valid[n] = 0;
                    else m_mask[n] = m_mask[n] & ~sm;
                end else if (req_valid[n] && ((req_br_mask[n] & rm) == 0) && !byp[n]) begin
                    m_valid[n] = 1;
                    m_pr[n]    = req_pr[n];
                    m_data[n]  = req_data[n];
                    m_mask[n]  = req_br_mask[n] & ~sm;
                end
            end
        end
        for (int n = 0; n < NR; n++) e_ready[n] = !m_valid[n];
        #1;
        if (model_on) begin
            for (int k = 0; k < NP; k++) begin
                chk($sformatf("model done[%0d]", k), 32'(done[k]), 32'(e_done[k]));
                chk($sformatf("model done_addr[%0d]", k), 32'(done_addr[k]), 32'(e_addr[k]));
                chk($sformatf("model done_data[%0d]", k), done_data[k], e_data[k]);
            end
            chk("model req_ready", 32'(req_ready), 32'(e_ready));
            if (NP > 1 && done[0] && done[1]) begin
                checks++;
                if (done_addr[0] == done_addr[1]) begin
                    errors++;
                    $display("FAIL dup_done_addr: both ports %0h, required distinct", done_addr[0]);
                end
            end
            // Starvation bound: a held result leaves its slot within ceil(NR/NP) cycles.
            for (int n = 0; n < NR; n++) begin
                if (!req_ready[n]) begin
                    low_cnt[n]++;
                    checks++;
                    if (low_cnt[n] > (NR + NP - 1) / NP) begin
                        errors++;
                        $display("FAIL starvation fu%0d: held %0d cycles, limit %0d", n, low_cnt[n], (NR + NP - 1) / NP);
                    end
                end else begin
                    low_cnt[n] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        req_valid   = '0;
        recall      = 1'b0;
        resolve     = 1'b0;
        recall_tag  = '0;
        resolve_tag = '0;
    endtask

    task automatic put(input int i, input logic [PW-1:0] pr, input logic [31:0] d, input logic [3:0] m);
        req_valid[i]   = 1'b1;
        req_pr[i]      = pr;
        req_data[i]    = d;
        req_br_mask[i] = m;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int n = 0; n < NR; n++) low_cnt[n] = 0;
        reset       = 1'b1;
        req_pr      = '0;
        req_data    = '0;
        req_br_mask = '0;
        idle();
        tick();
        tick();
        chk("reset done", 32'(done), 32'h0);
        chk("reset done_addr0", 32'(done_addr[0]), 32'h0);
        chk("reset req_ready", 32'(req_ready), 32'hF);
        reset = 1'b0;
        tick();

        // Single request on FU1.
        put(1, 6'd5, 32'hAB, 4'b0000);
        tick();
        idle();
`ifdef WB_ARB_BYPASS_EN
        chk("single bypass done", 32'(done), 32'b01);
        chk("single bypass addr0", 32'(done_addr[0]), 32'd5);
        chk("single bypass data0", done_data[0], 32'hAB);
        chk("single bypass ready", 32'(req_ready), 32'hF);
`else
        chk("single ready low", 32'(req_ready), 32'b1101);
        tick();
        chk("single done", 32'(done), 32'b01);
        chk("single addr0", 32'(done_addr[0]), 32'd5);
        chk("single data0", done_data[0], 32'hAB);
        chk("single ready back", 32'(req_ready), 32'hF);
`endif
        tick();
        chk("single done drop", 32'(done), 32'h0);
        chk("single addr hold", 32'(done_addr[0]), 32'd5);

        // All four FUs at once from rr_ptr=0.
        do_reset();
        for (int i = 0; i < NR; i++) put(i, PW'(10 + i), 32'(100 + i), 4'b0000);
        tick();
        idle();
`ifdef WB_ARB_BYPASS_EN
        chk("all4 byp done", 32'(done), 32'b11);
        chk("all4 byp addr0", 32'(done_addr[0]), 32'd10);
        chk("all4 byp addr1", 32'(done_addr[1]), 32'd11);
        chk("all4 byp ready", 32'(req_ready), 32'b0011);
        put(0, 6'd14, 32'h14, 4'b0000);
        tick();
        idle();
        chk("all4 byp addr0 b", 32'(done_addr[0]), 32'd12);
        chk("all4 byp addr1 b", 32'(done_addr[1]), 32'd13);
        chk("no bypass when full ports", 32'(req_ready), 32'b1110);
        tick();
        chk("buffered after no-bypass done", 32'(done), 32'b01);
        chk("buffered after no-bypass addr", 32'(done_addr[0]), 32'd14);
        put(0, 6'd16, 32'h16, 4'b0000);
        put(3, 6'd19, 32'h19, 4'b0000);
        tick();
        idle();
        chk("rr order port0", 32'(done_addr[0]), 32'd19);
        chk("rr order port1", 32'(done_addr[1]), 32'd16);
`else
        chk("all4 ready", 32'(req_ready), 32'h0);
        tick();
        chk("all4 done a", 32'(done), 32'b11);
        chk("all4 addr0 a", 32'(done_addr[0]), 32'd10);
        chk("all4 addr1 a", 32'(done_addr[1]), 32'd11);
        tick();
        chk("all4 done b", 32'(done), 32'b11);
        chk("all4 addr0 b", 32'(done_addr[0]), 32'd12);
        chk("all4 addr1 b", 32'(done_addr[1]), 32'd13);
        chk("all4 data1 b", done_data[1], 32'd103);
        tick();
        chk("all4 drained", 32'(done), 32'h0);
        put(0, 6'd16, 32'h16, 4'b0000);
        put(3, 6'd19, 32'h19, 4'b0000);
        tick();
        idle();
        tick();
        chk("rr back to 0 port0", 32'(done_addr[0]), 32'd16);
        chk("rr back to 0 port1", 32'(done_addr[1]), 32'd19);
`endif
        tick();

        // Recall kills a buffered entry the cycle it would win.
        do_reset();
        put(0, 6'd20, 32'h200, 4'b0000);
        put(2, 6'd22, 32'h222, 4'b0010);
        tick();
        idle();
        recall     = 1'b1;
        recall_tag = 4'b0010;
        tick();
        idle();
`ifndef WB_ARB_BYPASS_EN
        chk("recall done", 32'(done), 32'b01);
        chk("recall survivor addr", 32'(done_addr[0]), 32'd20);
        chk("recall survivor data", done_data[0], 32'h200);
        chk("recall buffer empty", 32'(req_ready), 32'hF);
`endif
        tick();
        chk("recall no late done", 32'(done), 32'h0);

        // Incoming request killed by recall: accepted, never stored or bypassed.
        put(3, 6'd23, 32'h333, 4'b0100);
        recall     = 1'b1;
        recall_tag = 4'b0100;
        tick();
        idle();
        chk("killed incoming done", 32'(done), 32'h0);
        chk("killed incoming ready", 32'(req_ready), 32'hF);
        tick();
        chk("killed incoming no done", 32'(done), 32'h0);

        // Resolve on load clears bit 0, so a later recall of that branch spares it.
        put(1, 6'd30, 32'h300, 4'b0011);
        resolve     = 1'b1;
        resolve_tag = 4'b0001;
        tick();
        idle();
`ifdef WB_ARB_BYPASS_EN
        chk("resolve byp done", 32'(done), 32'b01);
        chk("resolve byp addr", 32'(done_addr[0]), 32'd30);
`else
        recall     = 1'b1;
        recall_tag = 4'b0001;
        tick();
        idle();
        chk("resolve survive done", 32'(done), 32'b01);
        chk("resolve survive addr", 32'(done_addr[0]), 32'd30);
`endif
        tick();

        // Reset with held results discards them.
        do_reset();
        for (int i = 0; i < 3; i++) put(i, PW'(40 + i), 32'(400 + i), 4'b0000);
        tick();
        idle();
        reset = 1'b1;
        tick();
        chk("midreset done", 32'(done), 32'h0);
        chk("midreset ready", 32'(req_ready), 32'hF);
        chk("midreset addr0", 32'(done_addr[0]), 32'h0);
        chk("midreset addr1", 32'(done_addr[1]), 32'h0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("midreset no later done", 32'(done), 32'h0);
        end

        // Mixed traffic with recalls and resolves; the model checks each cycle.
        for (int c = 0; c < 32; c++) begin
            idle();
            for (int i = 0; i < NR; i++) begin
                if (((c * 7 + i * 3) % 5) < 3) begin
                    put(i, PW'((c * NR + i) % WB_NUM_PR), 32'($urandom), 4'((c + i) % 4 == 0 ? 0 : (1 << ((c + i) % 4))));
                end
            end
            if (c % 5 == 3) begin recall = 1'b1; recall_tag = 4'(1 << (c % 4)); end
            if (c % 3 == 1) begin resolve = 1'b1; resolve_tag = 4'(1 << ((c + 1) % 4)); end
            tick();
        end
        idle();
        for (int c = 0; c < 5; c++) tick();
        chk("drain done", 32'(done), 32'h0);
        chk("drain ready", 32'(req_ready), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
